layer_out_serializer: RTL and testbench
=======================================

LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 30, the number of neuron outputs captured per layer.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, the width of each neuron output word.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports are clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 x_in  input  NUM_NEURONS*DATA_WIDTH  concatenated neuron outputs; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 x_valid  input  1  single-cycle pulse; all neuron outputs of the layer are valid this cycle.
REQ-008 data_out  output  DATA_WIDTH  serialized word, fed to the next layer's neuron input.
REQ-009 data_out_valid  output  1  data_out is valid this cycle, fed to the next layer's input-valid.
REQ-010 busy  output  1  serialization in progress.
REQ-011 overrun  output  1  sticky error: a capture request was dropped.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 In IDLE, x_valid=1 SHALL capture all NUM_NEURONS words into a holding register, clear the index counter to 0 and enter SHIFT on the next edge.
REQ-014 In SHIFT, each accepted beat SHALL drive data_out=word[idx] with data_out_valid=1 and then increment idx.
REQ-015 Latency: for x_valid at cycle t, word 0 SHALL appear at t+1 and word NUM_NEURONS-1 at t+NUM_NEURONS, with no bubbles when no stall occurs.
REQ-016 After the beat with idx=NUM_NEURONS-1, the block SHALL return to IDLE with data_out_valid=0.
REQ-017 If x_valid=1 on the final beat, the block SHALL capture the new set and remain in SHIFT with idx=0, so back-to-back layers stream with no gap.
REQ-018 If x_valid=1 in SHIFT on any non-final beat, the block SHALL ignore the new data, leave the current stream intact and set overrun to 1 until reset.
REQ-019 The idx counter SHALL be $clog2(NUM_NEURONS) bits wide and SHALL never exceed NUM_NEURONS-1; no wrap-around beat SHALL occur.
REQ-020 Words SHALL pass through unmodified, with no sign or width conversion.
REQ-021 busy SHALL be 1 exactly while the state is SHIFT.
REQ-022 data_out SHALL be registered; when data_out_valid=0 its value is don't-care but SHALL hold its last value.

Reset
REQ-023 When rst is asserted, the block SHALL asynchronously go to state IDLE, with idx=0, data_out=0, data_out_valid=0, busy=0 and overrun=0.
REQ-024 Reset asserted mid-stream SHALL abort the stream immediately; no further valid beats SHALL be emitted from the aborted set.
REQ-025 The holding register SHALL need no reset value.

Configuration
REQ-026 Macro LAYER_SER_BACKPRESSURE_EN defined: the block SHALL add input port ready (1 bit).
REQ-027 With LAYER_SER_BACKPRESSURE_EN, a beat SHALL be accepted only when data_out_valid=1 and ready=1.
REQ-028 With LAYER_SER_BACKPRESSURE_EN, while ready=0 the block SHALL hold data_out, data_out_valid and idx stable.
REQ-029 With LAYER_SER_BACKPRESSURE_EN, the final-beat rule of REQ-017 SHALL apply only on the accepted final beat.
REQ-030 Macro LAYER_SER_BACKPRESSURE_EN undefined: there SHALL be no ready port, and every valid beat is accepted.

Structure
REQ-031 The shared package fnn_pkg SHALL hold the FSM state enum ser_state_t {IDLE, SHIFT} and the default DATA_WIDTH constant.
REQ-032 The block SHALL be a single module with no sub-module; the holding register and index mux are inline.

Verification
REQ-033 NUM_NEURONS=4, x_in words {0x0001,0x0002,0x0003,0x0004}, x_valid at cycle 10 -> data_out 0x0001..0x0004 on cycles 11..14 with valid high, busy falling after cycle 14.
REQ-034 Back-to-back: second x_valid on cycle 14 with words {0x00A0..0x00A3} -> 0x00A0 at cycle 15, no gap, overrun=0.
REQ-035 Overrun: x_valid at cycle 12 during the stream -> stream 0x0001..0x0004 unchanged, overrun=1 from cycle 13 until rst.
REQ-036 Reset mid-stream: rst at cycle 12 -> data_out_valid=0, busy=0 and data_out=0 immediately; no further beats emitted.
REQ-037 With LAYER_SER_BACKPRESSURE_EN: ready=0 during cycles 12-13 -> 0x0002 held for 3 cycles, last word at cycle 16, each word delivered exactly once.
REQ-038 Default parameters (NUM_NEURONS=30): 30 beats in order, idx never reaches 30, and signed words such as 0xFD1F pass through bit-exact.

Source files
------------

// File: rtl/fnn_pkg.sv
// Shared definitions for the feed-forward network datapath blocks.
// Holds the serializer FSM state type and the default neuron word width.
package fnn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/layer_out_serializer.sv
// Captures a full layer of neuron outputs and streams them one word per beat.
// Optional downstream backpressure (ready input) is enabled by LAYER_SER_BACKPRESSURE_EN.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] x_in,
    input  logic                              x_valid,
`ifdef LAYER_SER_BACKPRESSURE_EN
    input  logic                              ready,
`endif
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_out_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    ser_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      next_idx;
    logic [DATA_WIDTH-1:0] hold [NUM_NEURONS];
    logic                  accept;
    logic                  last_beat;
    logic                  capture;

`ifdef LAYER_SER_BACKPRESSURE_EN
    assign accept = data_out_valid & ready;
`else
    assign accept = data_out_valid;
`endif

    // idx always names the word currently on data_out, so it stops at LAST_IDX
    assign last_beat = (idx == LAST_IDX);
    assign next_idx  = last_beat ? '0 : idx + 1'b1;
    assign capture   = x_valid && ((state == IDLE) || (accept && last_beat));

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                hold[k] <= x_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Word 0 is loaded straight from x_in at capture so it appears one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        state          <= SHIFT;
                        busy           <= 1'b1;
                        idx            <= '0;
                        data_out       <= x_in[DATA_WIDTH-1:0];
                        data_out_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (x_valid && !capture) begin
                        overrun <= 1'b1;
                    end
                    if (accept) begin
                        if (last_beat) begin
                            idx <= '0;
                            if (x_valid) begin
                                data_out <= x_in[DATA_WIDTH-1:0];
                            end else begin
                                state          <= IDLE;
                                busy           <= 1'b0;
                                data_out_valid <= 1'b0;
                            end
                        end else begin
                            idx      <= next_idx;
                            data_out <= hold[next_idx];
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    data_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed self-checking bench for layer_out_serializer (4-neuron and default 30-neuron instances).
// Backpressure steps are compiled in only when LAYER_SER_BACKPRESSURE_EN is defined.
module tb_layer_out_serializer;
    import fnn_pkg::*;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    logic [4*DW-1:0]  x_in4;
    logic             x_valid4;
    logic [DW-1:0]    data_out4;
    logic             data_out_valid4;
    logic             busy4;
    logic             overrun4;

    logic [30*DW-1:0] x_in30;
    logic             x_valid30;
    logic [DW-1:0]    data_out30;
    logic             data_out_valid30;
    logic             busy30;
    logic             overrun30;

`ifdef LAYER_SER_BACKPRESSURE_EN
    logic ready4;
    logic ready30;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_out_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(DW)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .x_in           (x_in4),
        .x_valid        (x_valid4),
`ifdef LAYER_SER_BACKPRESSURE_EN
        .ready          (ready4),
`endif
        .data_out       (data_out4),
        .data_out_valid (data_out_valid4),
        .busy           (busy4),
        .overrun        (overrun4)
    );

    layer_out_serializer dut30 (
        .clk            (clk),
        .rst            (rst),
        .x_in           (x_in30),
        .x_valid        (x_valid30),
`ifdef LAYER_SER_BACKPRESSURE_EN
        .ready          (ready30),
`endif
        .data_out       (data_out30),
        .data_out_valid (data_out_valid30),
        .busy           (busy30),
        .overrun        (overrun30)
    );

    // Advance one clock and settle just past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_beat4(input string tag, input logic [DW-1:0] word, input logic ovr);
        check_output({tag, " data"},    32'(data_out4), 32'(word));
        check_output({tag, " valid"},   32'(data_out_valid4), 32'd1);
        check_output({tag, " busy"},    32'(busy4), 32'd1);
        check_output({tag, " overrun"}, 32'(overrun4), 32'(ovr));
    endtask

    task automatic check_idle4(input string tag, input logic [DW-1:0] held, input logic ovr);
        check_output({tag, " data"},    32'(data_out4), 32'(held));
        check_output({tag, " valid"},   32'(data_out_valid4), 32'd0);
        check_output({tag, " busy"},    32'(busy4), 32'd0);
        check_output({tag, " overrun"}, 32'(overrun4), 32'(ovr));
    endtask

    // Present a new layer for exactly one cycle; word 0 is visible after this returns.
    task automatic apply_stimulus(input logic [4*DW-1:0] words);
        x_in4    = words;
        x_valid4 = 1'b1;
        tick();
        x_valid4 = 1'b0;
    endtask

    function automatic logic [DW-1:0] word30(input int k);
        return (k == 7) ? 16'hFD1F : 16'(16'h1000 + k);
    endfunction

    initial begin
        rst       = 1'b1;
        x_in4     = '0;
        x_valid4  = 1'b0;
        x_in30    = '0;
        x_valid30 = 1'b0;
`ifdef LAYER_SER_BACKPRESSURE_EN
        ready4    = 1'b1;
        ready30   = 1'b1;
`endif
        $display("[TB] start");
        repeat (3) tick();
        check_idle4("reset", 16'h0000, 1'b0);
        check_output("reset dut30 valid", 32'(data_out_valid30), 32'd0);
        check_output("reset dut30 busy",  32'(busy30), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic stream: words 1..4 on consecutive cycles, then idle holding the last word
        apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check_beat4("basic w0", 16'h0001, 1'b0);
        tick(); check_beat4("basic w1", 16'h0002, 1'b0);
        tick(); check_beat4("basic w2", 16'h0003, 1'b0);
        tick(); check_beat4("basic w3", 16'h0004, 1'b0);
        tick(); check_idle4("basic end", 16'h0004, 1'b0);
        tick(); check_idle4("basic hold", 16'h0004, 1'b0);

        // Back-to-back: new layer presented on the final beat streams with no gap
        apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check_beat4("b2b w0", 16'h0001, 1'b0);
        tick(); check_beat4("b2b w1", 16'h0002, 1'b0);
        tick(); check_beat4("b2b w2", 16'h0003, 1'b0);
        tick(); check_beat4("b2b w3", 16'h0004, 1'b0);
        apply_stimulus({16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
        check_beat4("b2b a0", 16'h00A0, 1'b0);
        tick(); check_beat4("b2b a1", 16'h00A1, 1'b0);
        tick(); check_beat4("b2b a2", 16'h00A2, 1'b0);
        tick(); check_beat4("b2b a3", 16'h00A3, 1'b0);
        tick(); check_idle4("b2b end", 16'h00A3, 1'b0);

        // Overrun: a capture request mid-stream is dropped and flagged until reset
        apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check_beat4("ovr w0", 16'h0001, 1'b0);
        tick(); check_beat4("ovr w1", 16'h0002, 1'b0);
        apply_stimulus({16'h00BB, 16'h00BB, 16'h00BB, 16'h00BB});
        check_beat4("ovr w2", 16'h0003, 1'b1);
        tick(); check_beat4("ovr w3", 16'h0004, 1'b1);
        tick(); check_idle4("ovr end", 16'h0004, 1'b1);
        tick(); check_idle4("ovr sticky", 16'h0004, 1'b1);
        rst = 1'b1;
        #1;
        check_idle4("ovr cleared", 16'h0000, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-stream aborts immediately and nothing more is emitted
        apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check_beat4("abort w0", 16'h0001, 1'b0);
        tick(); check_beat4("abort w1", 16'h0002, 1'b0);
        rst = 1'b1;
        #1;
        check_idle4("abort async", 16'h0000, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle4("abort quiet", 16'h0000, 1'b0);
        end

`ifdef LAYER_SER_BACKPRESSURE_EN
        // Stall: ready low for two cycles while word 1 is presented; each word delivered once
        apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check_beat4("bp w0", 16'h0001, 1'b0);
        tick(); check_beat4("bp w1", 16'h0002, 1'b0);
        ready4 = 1'b0;
        tick(); check_beat4("bp hold1", 16'h0002, 1'b0);
        tick(); check_beat4("bp hold2", 16'h0002, 1'b0);
        ready4 = 1'b1;
        tick(); check_beat4("bp w2", 16'h0003, 1'b0);
        tick(); check_beat4("bp w3", 16'h0004, 1'b0);
        tick(); check_idle4("bp end", 16'h0004, 1'b0);
`endif

        // Default 30-neuron instance: all beats in order, signed word bit-exact, no wrap beat
        for (int k = 0; k < 30; k++) begin
            x_in30[k*DW +: DW] = word30(k);
        end
        x_valid30 = 1'b1;
        tick();
        x_valid30 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            check_output($sformatf("n30 w%0d data", k), 32'(data_out30), 32'(word30(k)));
            check_output($sformatf("n30 w%0d valid", k), 32'(data_out_valid30), 32'd1);
            tick();
        end
        check_output("n30 end valid", 32'(data_out_valid30), 32'd0);
        check_output("n30 end busy",  32'(busy30), 32'd0);
        check_output("n30 end data",  32'(data_out30), 32'(word30(29)));
        check_output("n30 overrun",   32'(overrun30), 32'd0);
        tick();
        check_output("n30 no wrap",   32'(data_out_valid30), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
